// File: rtl/mem_sched.sv
// Round-robin memory access scheduler: grants one client at a time and sequences its access through an IDLE/ACCESS/DONE FSM.
// Define MEM_SCHED_PRIO_EN to give client CLIENT_CNT-1 strict priority over the round-robin group.
module mem_sched #(
  parameter int M_WIDTH     = 8,
  parameter int CLIENT_CNT  = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENT_CNT-1:0]         requests,
  input  logic [M_WIDTH*CLIENT_CNT-1:0] addrs,
  input  logic [CLIENT_CNT-1:0]         wes,
  input  logic [M_WIDTH*CLIENT_CNT-1:0] data_outs,
  output logic [CLIENT_CNT-1:0]         readies,
  output logic [M_WIDTH-1:0]            addr,
  output logic [M_WIDTH-1:0]            data_out,
  output logic                          we,
  output logic                          busy,
  output logic [$clog2(CLIENT_CNT)-1:0] grant_id
);

  localparam int GW = $clog2(CLIENT_CNT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [M_WIDTH-1:0]    addr_q, addr_d;
  logic [M_WIDTH-1:0]    data_q, data_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic [CLIENT_CNT-1:0] readies_q, readies_d;

  logic [M_WIDTH-1:0] addrArr [CLIENT_CNT];
  logic [M_WIDTH-1:0] dataArr [CLIENT_CNT];

  for (genvar i = 0; i < CLIENT_CNT; i++) begin : g_unpack
    assign addrArr[i] = addrs[M_WIDTH*i +: M_WIDTH];
    assign dataArr[i] = data_outs[M_WIDTH*i +: M_WIDTH];
  end

  // Winner search starts just after the last granted client and wraps around.
  logic [GW-1:0] winner;
  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 1; k <= CLIENT_CNT; k++) begin
      idx = GW'((int'(last_grant_q) + k) % CLIENT_CNT);
      if (!found && requests[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
`ifdef MEM_SCHED_PRIO_EN
    if (requests[CLIENT_CNT-1]) begin
      winner = GW'(CLIENT_CNT-1);
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = we_q;
    busy_d       = busy_q;
    readies_d    = readies_q;
    case (state_q)
      IDLE: begin
        if (|requests) begin
          grant_d      = winner;
          last_grant_d = winner;
          addr_d       = addrArr[winner];
          data_d       = dataArr[winner];
          we_d         = wes[winner];
          cnt_d        = 4'(WAIT_STATES);
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // A dropped request aborts silently, even on the cycle the access would complete.
        if (!requests[grant_q]) begin
          we_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          we_d               = 1'b0;
          readies_d          = '0;
          readies_d[grant_q] = 1'b1;
          state_d            = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!requests[grant_q]) begin
          readies_d = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        we_d      = 1'b0;
        readies_d = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(CLIENT_CNT-1);
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      readies_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      readies_q    <= readies_d;
    end
  end

  assign readies  = readies_q;
  assign addr     = addr_q;
  assign data_out = data_q;
  assign we       = we_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: directed scenarios push expected completions, a negedge monitor pops and compares them.
// Contention expectations follow MEM_SCHED_PRIO_EN when it is defined for the build.
module tb_mem_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  requests;
  logic [15:0] addrs;
  logic [1:0]  wes;
  logic [15:0] data_outs;
  logic [1:0]  readies;
  logic [7:0]  addr;
  logic [7:0]  data_out;
  logic        we;
  logic        busy;
  logic [0:0]  grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int client;
    int addr;
    int data;
  } exp_t;

  exp_t sbQ[$];

  mem_sched #(.M_WIDTH(8), .CLIENT_CNT(2), .WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .requests(requests), .addrs(addrs), .wes(wes),
    .data_outs(data_outs), .readies(readies), .addr(addr), .data_out(data_out),
    .we(we), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] w,
                               input logic [15:0] a, input logic [15:0] d);
    requests  = req;
    wes       = w;
    addrs     = a;
    data_outs = d;
  endtask

  task automatic waitReady(input int budget, output int cyc);
    cyc = 0;
    while (readies == 2'b00 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (readies == 2'b00) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout actual=none required=ready within %0d cycles", budget);
    end
  endtask

  function automatic int expGrant(input int n);
`ifdef MEM_SCHED_PRIO_EN
    return 1;
`else
    return n % 2;
`endif
  endfunction

  // Monitor: every rising readies must match the oldest expected completion.
  logic [1:0] prevReadies = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    if (readies != 2'b00 && prevReadies == 2'b00) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedReady actual=%b required=none", readies);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sbReadies", int'(readies), 1 << e.client);
        checkOutput("sbGrant", int'(grant_id), e.client);
        checkOutput("sbAddr", int'(addr), e.addr);
        checkOutput("sbData", int'(data_out), e.data);
      end
    end
    checkOutput("weReadyOverlap", int'(we && readies != 2'b00), 0);
    checkOutput("readyWhileIdle", int'(readies != 2'b00 && !busy), 0);
    prevReadies <= readies;
  end

  initial begin
    int cyc;
    int g;

    rst = 1'b1;
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    tick();
    tick();
    checkOutput("rstReadies", int'(readies), 0);
    checkOutput("rstWe", int'(we), 0);
    checkOutput("rstAddr", int'(addr), 0);
    checkOutput("rstData", int'(data_out), 0);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstGrant", int'(grant_id), 0);
    rst = 1'b0;
    tick();

    $display("[TB] single read, client 0");
    applyStimulus(2'b01, 2'b00, 16'h0010, 16'h0033);
    sbQ.push_back('{0, 8'h10, 8'h33});
    tick();
    checkOutput("rdAddr", int'(addr), 8'h10);
    checkOutput("rdBusy", int'(busy), 1);
    checkOutput("rdWe", int'(we), 0);
    checkOutput("rdEarlyReady", int'(readies), 0);
    addrs = 16'h0077;
    tick();
    checkOutput("rdHoldAddr", int'(addr), 8'h10);
    checkOutput("rdNotYet", int'(readies), 0);
    tick();
    checkOutput("rdReady", int'(readies), 2'b01);
    tick();
    checkOutput("rdReadyHeld", int'(readies), 2'b01);
    requests = 2'b00;
    tick();
    checkOutput("rdReadyClear", int'(readies), 0);
    checkOutput("rdIdle", int'(busy), 0);

    $display("[TB] write, client 1");
    applyStimulus(2'b10, 2'b10, 16'h2A00, 16'h5C00);
    sbQ.push_back('{1, 8'h2A, 8'h5C});
    tick();
    checkOutput("wrWe0", int'(we), 1);
    checkOutput("wrAddr", int'(addr), 8'h2A);
    checkOutput("wrData", int'(data_out), 8'h5C);
    checkOutput("wrGrant", int'(grant_id), 1);
    data_outs = 16'h0000;
    wes = 2'b00;
    tick();
    checkOutput("wrWe1", int'(we), 1);
    checkOutput("wrHoldData", int'(data_out), 8'h5C);
    tick();
    checkOutput("wrWeDrop", int'(we), 0);
    checkOutput("wrReady", int'(readies), 2'b10);
    requests = 2'b00;
    tick();
    checkOutput("wrReadyClear", int'(readies), 0);

    $display("[TB] contention");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 16'h4140, 16'h9190);
    for (int n = 0; n < 4; n++) begin
      g = expGrant(n);
      sbQ.push_back('{g, 8'h40 + g, 8'h90 + g});
      waitReady(8, cyc);
      checkOutput("contLatency", cyc, 3);
      requests[g] = 1'b0;
      tick();
      checkOutput("contGapBusy", int'(busy), 0);
      checkOutput("contGapReady", int'(readies), 0);
      requests[g] = 1'b1;
    end
    requests = 2'b00;
    tick();
    tick();

    $display("[TB] abort, client 0 write");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b01, 2'b01, 16'h6655, 16'hB6A5);
    tick();
    checkOutput("abGrant0", int'(grant_id), 0);
    checkOutput("abWe", int'(we), 1);
    checkOutput("abAddr", int'(addr), 8'h55);
    requests = 2'b10;
    sbQ.push_back('{1, 8'h66, 8'hB6});
    tick();
    checkOutput("abWeDrop", int'(we), 0);
    checkOutput("abIdle", int'(busy), 0);
    checkOutput("abNoReady", int'(readies), 0);
    tick();
    checkOutput("abGrant1", int'(grant_id), 1);
    checkOutput("abBusy1", int'(busy), 1);
    waitReady(6, cyc);
    checkOutput("abLatency", cyc, 2);
    requests = 2'b00;
    tick();

    $display("[TB] reset during write");
    applyStimulus(2'b10, 2'b10, 16'h7712, 16'hC334);
    tick();
    checkOutput("mrWe", int'(we), 1);
    checkOutput("mrBusy", int'(busy), 1);
    rst = 1'b1;
    tick();
    checkOutput("mrWeDrop", int'(we), 0);
    checkOutput("mrBusyDrop", int'(busy), 0);
    checkOutput("mrReadies", int'(readies), 0);
    checkOutput("mrGrant", int'(grant_id), 0);
    checkOutput("mrAddr", int'(addr), 0);
    rst = 1'b0;
    wes = 2'b00;
`ifdef MEM_SCHED_PRIO_EN
    requests = 2'b01;
`else
    requests = 2'b11;
`endif
    sbQ.push_back('{0, 8'h12, 8'h34});
    tick();
    checkOutput("mrNextGrant", int'(grant_id), 0);
    waitReady(6, cyc);
    checkOutput("mrLatency", cyc, 2);
    requests = 2'b00;
    tick();
    tick();

    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter M_WIDTH, default 8, width of address and data buses.
REQ-002 Parameter CLIENT_CNT, default 2, number of memory requesters (2..8).
REQ-003 Parameter WAIT_STATES, default 1, memory cycles between address launch and data valid (0..15).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset; rst is synchronous, active-high.
REQ-006 requests  input  CLIENT_CNT  per-client request level, bit i = client i.
REQ-007 addrs  input  M_WIDTH*CLIENT_CNT  packed client addresses, client i at [M_WIDTH*i +: M_WIDTH].
REQ-008 wes  input  CLIENT_CNT  per-client write enable qualifier.
REQ-009 data_outs  input  M_WIDTH*CLIENT_CNT  packed client write data, same packing as addrs.
REQ-010 readies  output  CLIENT_CNT  per-client completion, one-hot or zero.
REQ-011 addr  output  M_WIDTH  memory address.
REQ-012 data_out  output  M_WIDTH  memory write data.
REQ-013 we  output  1  memory write strobe.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 grant_id  output  $clog2(CLIENT_CNT)  index of client currently owning the bus.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE; all outputs registered.
REQ-017 IDLE: if any requests bit set at an edge, SHALL grant one client, latch its addr/we/data into addr/we/data_out, load wait counter with WAIT_STATES, enter ACCESS.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo CLIENT_CNT; last_grant updates on each grant.
REQ-019 addr, data_out, we SHALL hold latched values throughout ACCESS regardless of client input changes.
REQ-020 ACCESS: counter SHALL decrement each cycle; at counter==0 SHALL deassert we, set readies[grant_id], enter DONE.
REQ-021 Latency: readies bit high exactly WAIT_STATES+1 cycles after the granting edge.
REQ-022 DONE: readies bit SHALL stay high while requests[grant_id] high; on the edge requests[grant_id] is low, readies clears and state returns to IDLE (no new grant that edge).
REQ-023 Requester dropping request during ACCESS SHALL abort: next edge we=0, no ready pulse, state IDLE.
REQ-024 Requests from non-granted clients SHALL be ignored until IDLE; they are not queued.
REQ-025 we SHALL never be high outside ACCESS; readies SHALL never be high outside DONE.

Reset
REQ-026 rst SHALL force IDLE, readies=0, we=0, addr=0, data_out=0, busy=0, grant_id=0, last_grant=CLIENT_CNT-1 (client 0 wins first), counter=0.
REQ-027 rst mid-ACCESS or mid-DONE SHALL drop we and readies on that same edge; no partial completion signalled.

Configuration
REQ-028 Macro MEM_SCHED_PRIO_EN defined: client CLIENT_CNT-1 SHALL have strict priority over all others whenever it requests in IDLE; remaining clients round-robin among themselves.
REQ-029 MEM_SCHED_PRIO_EN undefined: pure round-robin per REQ-018, no client favoured.

Verification
REQ-030 Single read: WAIT_STATES=1, client 0 req, addr 0x10, we 0 -> addr=0x10 after grant edge, readies=01 two cycles later, clears one edge after req drops.
REQ-031 Write: client 1 addr 0x2A, data 0x5C, we 1 -> we=1 for 2 cycles with addr 0x2A/data_out 0x5C, then we=0 and readies=10.
REQ-032 Contention, macro undefined: both request continuously out of reset -> grants alternate 0,1,0,1; each readies pulse separated by one IDLE cycle.
REQ-033 Contention, MEM_SCHED_PRIO_EN defined: both request continuously -> client 1 granted every time, client 0 starved while client 1 requests.
REQ-034 Abort: client 0 drops req one cycle after grant with WAIT_STATES=3 -> no readies, we low, IDLE next edge, client 1 pending request granted following edge.
REQ-035 Reset mid-ACCESS write (we=1) -> we=0, busy=0, readies=0 after that edge; next grant goes to client 0.
